// File: rtl/display_pkg.sv
// display_pkg
//   Shared constants, types and helpers for the display scan-out path.
//   COLR_W_DEFAULT : default pixel colour width (RGB 4:4:4)
//   MAX_SCALE      : largest supported integer upscale factor
//   MAX_MEM_LAT    : largest supported framebuffer read latency
//   sync_state_t   : whether the scan-out has seen a frame start since reset
//   clog2()        : ceiling log2, used to size the scale counters
package display_pkg;

    localparam int COLR_W_DEFAULT = 12;
    localparam int MAX_SCALE      = 8;
    localparam int MAX_MEM_LAT    = 4;

    typedef enum logic {
        ST_UNSYNCED = 1'b0,
        ST_SYNCED   = 1'b1
    } sync_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// pipe_delay
//   Fixed-depth shift register with synchronous reset to a chosen idle value.
//   Ports:
//     i_pix_clk : clock
//     i_rst     : synchronous active-high reset, loads every stage with RST_VAL
//     i_d       : WIDTH-bit input
//     o_q       : i_d delayed by DEPTH clock cycles
module pipe_delay
    import display_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_pix_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RST_VAL;
            end
        end else begin
            stages[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign o_q = stages[DEPTH-1];

endmodule

// File: rtl/display_fb_scanout.sv
// display_fb_scanout
//   Converts beam position and display enable into framebuffer read addresses
//   with integer pixel replication, and delays the syncs and enable so that the
//   returned colour leaves the block aligned with them.
//   Ports:
//     i_pix_clk, i_rst     : pixel clock, synchronous active-high reset
//     i_hs, i_vs, i_de     : syncs and display enable from the timing generator
//     i_frame              : one-tick start-of-frame strobe (in blanking)
//     i_sx, i_sy           : signed beam position (i_sy only feeds assertions)
//     o_rd_en, o_rd_addr   : framebuffer read strobe and address
//     i_rd_data            : read data, valid MEM_LAT cycles after o_rd_en
//     o_hs, o_vs, o_de     : syncs and enable delayed by MEM_LAT+2 cycles
//     o_colr               : pixel colour, forced to 0 outside active video
module display_fb_scanout
    import display_pkg::*;
#(
    parameter int   H_RES   = 640,
    parameter int   V_RES   = 480,
    parameter int   SCALE   = 2,
    parameter int   MEM_LAT = 2,
    parameter int   ADDR_W  = 17,
    parameter int   COLR_W  = COLR_W_DEFAULT,
    parameter logic H_POL   = 1'b0,
    parameter logic V_POL   = 1'b0
) (
    input  logic                     i_pix_clk,
    input  logic                     i_rst,
    input  logic                     i_hs,
    input  logic                     i_vs,
    input  logic                     i_de,
    input  logic                     i_frame,
    input  logic signed [15:0]       i_sx,
    input  logic signed [15:0]       i_sy,
    output logic                     o_rd_en,
    output logic        [ADDR_W-1:0] o_rd_addr,
    input  logic        [COLR_W-1:0] i_rd_data,
    output logic                     o_hs,
    output logic                     o_vs,
    output logic                     o_de,
    output logic        [COLR_W-1:0] o_colr
);

    localparam int FB_W  = H_RES / SCALE;
    localparam int FB_H  = V_RES / SCALE;
    localparam int LAT   = MEM_LAT + 2;
    localparam int CNT_W = clog2(MAX_SCALE);

    localparam logic        [CNT_W-1:0]  CNT_LAST = CNT_W'(SCALE - 1);
    localparam logic        [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);
    localparam logic signed [15:0]       SX_LAST  = 16'(H_RES - 1);
    localparam logic signed [15:0]       SY_END   = 16'(V_RES);

    if (SCALE < 1 || SCALE > MAX_SCALE) begin : g_bad_scale
        $error("display_fb_scanout: SCALE must be 1..%0d", MAX_SCALE);
    end
    if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_lat
        $error("display_fb_scanout: MEM_LAT must be 1..%0d", MAX_MEM_LAT);
    end
    if (longint'(FB_W) * longint'(FB_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("display_fb_scanout: framebuffer does not fit in ADDR_W bits");
    end

    sync_state_t       state;
    sync_state_t       state_next;
    logic              synced;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;
    logic [COLR_W-1:0] colr_q;
    logic [3:0]        pipe_in;
    logic [3:0]        pipe_out;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            state <= ST_UNSYNCED;
        end else begin
            state <= state_next;
        end
    end

    // Reads are only issued once a frame start has been seen, so a reset in
    // mid-frame never produces addresses that disagree with the beam.
    always_comb begin
        state_next = state;
        synced     = (state == ST_SYNCED);
        if (i_frame) begin
            state_next = ST_SYNCED;
        end
    end

    // Each source pixel is read SCALE times along a line, and each source line
    // is replayed SCALE times before line_base steps to the next one. The
    // end-of-line case overrides the horizontal step so a line never spills
    // into the following one.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            addr      <= '0;
            line_base <= '0;
        end else begin
            o_rd_en <= i_de && synced;
            if (i_de && synced) begin
                o_rd_addr <= addr;
            end
            if (i_frame) begin
                hcnt      <= '0;
                vcnt      <= '0;
                addr      <= '0;
                line_base <= '0;
            end else if (i_de && synced) begin
                if (i_sx == SX_LAST) begin
                    hcnt <= '0;
                    if (vcnt == CNT_LAST) begin
                        vcnt      <= '0;
                        line_base <= line_base + FB_W_A;
                        addr      <= line_base + FB_W_A;
                    end else begin
                        vcnt <= vcnt + CNT_W'(1);
                        addr <= line_base;
                    end
                end else if (hcnt == CNT_LAST) begin
                    hcnt <= '0;
                    addr <= addr + ADDR_W'(1);
                end else begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end
        end
    end

    // Capture the memory output one cycle after it becomes valid; this extra
    // stage is what makes the overall latency MEM_LAT+2.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            colr_q <= '0;
        end else begin
            colr_q <= i_rd_data;
        end
    end

    assign pipe_in = {i_hs, i_vs, i_de, synced};

    pipe_delay #(
        .WIDTH   (4),
        .DEPTH   (LAT),
        .RST_VAL ({~H_POL, ~V_POL, 2'b00})
    ) u_sync_pipe (
        .i_pix_clk (i_pix_clk),
        .i_rst     (i_rst),
        .i_d       (pipe_in),
        .o_q       (pipe_out)
    );

    assign o_hs   = pipe_out[3];
    assign o_vs   = pipe_out[2];
    assign o_de   = pipe_out[1];
    assign o_colr = (pipe_out[1] && pipe_out[0]) ? colr_q : '0;

    a_sy_in_range: assert property (@(posedge i_pix_clk) disable iff (i_rst)
        i_de |-> (i_sy >= 16'sd0 && i_sy < SY_END));

    a_addr_in_range: assert property (@(posedge i_pix_clk) disable iff (i_rst)
        o_rd_en |-> (32'(o_rd_addr) < 32'(FB_W * FB_H)));

endmodule

// File: tb/tb_display_fb_scanout.sv
// tb_display_fb_scanout
//   Drives two scan-out instances from a small timing pattern (32x8 active,
//   40x10 total): instance A uses SCALE=2, MEM_LAT=2 with negative syncs,
//   instance B uses SCALE=1, MEM_LAT=1 with positive syncs. Each has a
//   memory model returning the low address bits after its read latency.
module tb_display_fb_scanout;

    localparam int H_RES     = 32;
    localparam int V_RES     = 8;
    localparam int SCALE_A   = 2;
    localparam int MEM_LAT_A = 2;
    localparam int LAT_A     = MEM_LAT_A + 2;
    localparam int FB_W_A    = H_RES / SCALE_A;
    localparam int SCALE_B   = 1;
    localparam int MEM_LAT_B = 1;
    localparam int LAT_B     = MEM_LAT_B + 2;
    localparam int FB_W_B    = H_RES / SCALE_B;
    localparam int MAX_TICKS = 4096;
    localparam int NO_RST    = -99;

    localparam logic [2:0] IDLE_A = 3'b110;
    localparam logic [2:0] IDLE_B = 3'b000;

    typedef struct {
        int   sy;
        logic frame;
        int   rst_sx;
        int   rd_cnt;
        int   a_first;
        int   a_last;
        int   b_first;
        int   b_last;
    } line_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               hs;
    logic               vs;
    logic               de;
    logic               frame;
    logic               hs_p;
    logic               vs_p;
    logic signed [15:0] sx;
    logic signed [15:0] sy;

    logic        rd_en_a, hs_a, vs_a, de_a;
    logic [16:0] rd_addr_a;
    logic [11:0] rd_data_a, colr_a;
    logic        rd_en_b, hs_b, vs_b, de_b;
    logic [16:0] rd_addr_b;
    logic [11:0] rd_data_b, colr_b;

    logic [16:0] mem_a0 = '0;
    logic [16:0] mem_a1 = '0;
    logic [16:0] mem_b0 = '0;

    logic [2:0]  sync_hist_a [MAX_TICKS];
    logic [2:0]  sync_hist_b [MAX_TICKS];
    logic [11:0] col_hist_a  [MAX_TICKS];
    logic [11:0] col_hist_b  [MAX_TICKS];

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   tick         = 0;
    logic synced_m     = 1'b0;
    int   last_a       = 0;
    int   last_b       = 0;
    int   line_cnt, line_a_first, line_a_last, line_b_first, line_b_last;
    logic prev_in_de   = 1'b0;
    logic prev_de_a    = 1'b0;
    logic prev_de_b    = 1'b0;
    int   in_rise      = -1;
    int   out_rise_a   = -1;
    int   out_rise_b   = -1;

    line_vec_t vecs[$];

    assign hs_p = ~hs;
    assign vs_p = ~vs;

    // Framebuffer models: registered address pipelines, data = low address bits.
    always @(posedge clk) begin
        mem_a0 <= rd_addr_a;
        mem_a1 <= mem_a0;
        mem_b0 <= rd_addr_b;
    end
    assign rd_data_a = mem_a1[11:0];
    assign rd_data_b = mem_b0[11:0];

    display_fb_scanout #(
        .H_RES(H_RES), .V_RES(V_RES), .SCALE(SCALE_A), .MEM_LAT(MEM_LAT_A),
        .ADDR_W(17), .COLR_W(12), .H_POL(1'b0), .V_POL(1'b0)
    ) dut_a (
        .i_pix_clk(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de),
        .i_frame(frame), .i_sx(sx), .i_sy(sy), .o_rd_en(rd_en_a),
        .o_rd_addr(rd_addr_a), .i_rd_data(rd_data_a), .o_hs(hs_a),
        .o_vs(vs_a), .o_de(de_a), .o_colr(colr_a)
    );

    display_fb_scanout #(
        .H_RES(H_RES), .V_RES(V_RES), .SCALE(SCALE_B), .MEM_LAT(MEM_LAT_B),
        .ADDR_W(17), .COLR_W(12), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .i_pix_clk(clk), .i_rst(rst), .i_hs(hs_p), .i_vs(vs_p), .i_de(de),
        .i_frame(frame), .i_sx(sx), .i_sy(sy), .o_rd_en(rd_en_b),
        .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b), .o_hs(hs_b),
        .o_vs(vs_b), .o_de(de_b), .o_colr(colr_b)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s (tick %0d): got %0d, expected %0d", name, tick, actual, expected);
        end
    endtask

    // One pixel clock: drive inputs, record expected delayed outputs, then
    // check everything the DUTs present after the clock edge.
    task automatic applyStimulus(input logic t_rst, input logic t_frame, input int t_sx, input int t_sy);
        logic t_de, t_hs, t_vs, en_exp;
        int   addr_exp_a, addr_exp_b, idx;
        logic [2:0]  exp_sync;
        logic [11:0] exp_col;
        t_de       = (t_sx >= 0) && (t_sy >= 0);
        t_hs       = !((t_sx >= -6) && (t_sx <= -3));
        t_vs       = (t_sy != -2);
        rst        = t_rst;
        frame      = t_frame;
        hs         = t_hs;
        vs         = t_vs;
        de         = t_de;
        sx         = 16'(t_sx);
        sy         = 16'(t_sy);
        en_exp     = !t_rst && t_de && synced_m;
        addr_exp_a = (t_sy / SCALE_A) * FB_W_A + t_sx / SCALE_A;
        addr_exp_b = t_sy * FB_W_B + t_sx;
        sync_hist_a[tick] = {t_hs, t_vs, t_de};
        sync_hist_b[tick] = {!t_hs, !t_vs, t_de};
        col_hist_a[tick]  = en_exp ? 12'(addr_exp_a) : 12'd0;
        col_hist_b[tick]  = en_exp ? 12'(addr_exp_b) : 12'd0;
        if (t_rst) begin
            for (int i = 0; i < LAT_A; i++) begin
                if (tick - i >= 0) begin
                    sync_hist_a[tick-i] = IDLE_A;
                    col_hist_a[tick-i]  = 12'd0;
                end
            end
            for (int i = 0; i < LAT_B; i++) begin
                if (tick - i >= 0) begin
                    sync_hist_b[tick-i] = IDLE_B;
                    col_hist_b[tick-i]  = 12'd0;
                end
            end
        end
        if (t_de && !prev_in_de) in_rise = tick;
        prev_in_de = t_de;

        @(posedge clk);
        #1;

        checkOutput("rd_en_a", int'(rd_en_a), int'(en_exp));
        checkOutput("rd_en_b", int'(rd_en_b), int'(en_exp));
        if (t_rst) begin
            last_a = 0;
            last_b = 0;
        end else if (en_exp) begin
            last_a = addr_exp_a;
            last_b = addr_exp_b;
        end
        checkOutput("rd_addr_a", int'(rd_addr_a), last_a);
        checkOutput("rd_addr_b", int'(rd_addr_b), last_b);

        idx      = tick - (LAT_A - 1);
        exp_sync = (idx >= 0) ? sync_hist_a[idx] : IDLE_A;
        exp_col  = (idx >= 0) ? col_hist_a[idx] : 12'd0;
        checkOutput("hs_vs_de_a", int'({hs_a, vs_a, de_a}), int'(exp_sync));
        checkOutput("colr_a", int'(colr_a), int'(exp_col));
        idx      = tick - (LAT_B - 1);
        exp_sync = (idx >= 0) ? sync_hist_b[idx] : IDLE_B;
        exp_col  = (idx >= 0) ? col_hist_b[idx] : 12'd0;
        checkOutput("hs_vs_de_b", int'({hs_b, vs_b, de_b}), int'(exp_sync));
        checkOutput("colr_b", int'(colr_b), int'(exp_col));

        if (rd_en_a) begin
            if (line_cnt == 0) begin
                line_a_first = int'(rd_addr_a);
                line_b_first = int'(rd_addr_b);
            end
            line_a_last = int'(rd_addr_a);
            line_b_last = int'(rd_addr_b);
            line_cnt++;
        end
        if (de_a && !prev_de_a) out_rise_a = tick;
        if (de_b && !prev_de_b) out_rise_b = tick;
        prev_de_a = de_a;
        prev_de_b = de_b;

        if (t_rst) synced_m = 1'b0;
        else if (t_frame) synced_m = 1'b1;
        tick++;
    endtask

    task automatic addFrame(input int rst_line);
        vecs.push_back('{-2, 1'b1, NO_RST, 0, 0, 0, 0, 0});
        vecs.push_back('{-1, 1'b0, NO_RST, 0, 0, 0, 0, 0});
        if (rst_line < 0) begin
            vecs.push_back('{0, 1'b0, NO_RST, 32,  0, 15,   0,  31});
            vecs.push_back('{1, 1'b0, NO_RST, 32,  0, 15,  32,  63});
            vecs.push_back('{2, 1'b0, NO_RST, 32, 16, 31,  64,  95});
            vecs.push_back('{3, 1'b0, NO_RST, 32, 16, 31,  96, 127});
            vecs.push_back('{4, 1'b0, NO_RST, 32, 32, 47, 128, 159});
            vecs.push_back('{5, 1'b0, NO_RST, 32, 32, 47, 160, 191});
            vecs.push_back('{6, 1'b0, NO_RST, 32, 48, 63, 192, 223});
            vecs.push_back('{7, 1'b0, NO_RST, 32, 48, 63, 224, 255});
        end else begin
            vecs.push_back('{0, 1'b0, NO_RST, 32,  0, 15,   0,  31});
            vecs.push_back('{1, 1'b0, NO_RST, 32,  0, 15,  32,  63});
            vecs.push_back('{2, 1'b0, 10,     10, 16, 20,  64,  73});
            for (int y = 3; y < V_RES; y++) begin
                vecs.push_back('{y, 1'b0, NO_RST, 0, 0, 0, 0, 0});
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Lines seen before any frame start, then three frames; the second
        // frame takes a reset on line 2 and the third must match the first.
        vecs.push_back('{6, 1'b0, NO_RST, 0, 0, 0, 0, 0});
        vecs.push_back('{7, 1'b0, NO_RST, 0, 0, 0, 0, 0});
        addFrame(-1);
        addFrame(2);
        addFrame(-1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, -8, -1);
        end
        checkOutput("reset rd_en_a", int'(rd_en_a), 0);
        checkOutput("reset rd_addr_a", int'(rd_addr_a), 0);
        checkOutput("reset de_a", int'(de_a), 0);
        checkOutput("reset colr_a", int'(colr_a), 0);
        checkOutput("reset hs_a", int'(hs_a), 1);
        checkOutput("reset vs_a", int'(vs_a), 1);
        checkOutput("reset hs_b", int'(hs_b), 0);
        checkOutput("reset vs_b", int'(vs_b), 0);

        foreach (vecs[v]) begin
            line_cnt     = 0;
            line_a_first = -1;
            line_a_last  = -1;
            line_b_first = -1;
            line_b_last  = -1;
            for (int x = -8; x < H_RES; x++) begin
                applyStimulus(x == vecs[v].rst_sx, vecs[v].frame && (x == -8), x, vecs[v].sy);
            end
            checkOutput($sformatf("line %0d reads", v), line_cnt, vecs[v].rd_cnt);
            if (vecs[v].rd_cnt > 0) begin
                checkOutput($sformatf("line %0d a_first", v), line_a_first, vecs[v].a_first);
                checkOutput($sformatf("line %0d a_last", v), line_a_last, vecs[v].a_last);
                checkOutput($sformatf("line %0d b_first", v), line_b_first, vecs[v].b_first);
                checkOutput($sformatf("line %0d b_last", v), line_b_last, vecs[v].b_last);
            end
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, -8 + i, -2);
        end
        checkOutput("de latency a", out_rise_a - in_rise, LAT_A - 1);
        checkOutput("de latency b", out_rise_b - in_rise, LAT_B - 1);
        checkOutput("blank colr_a", int'(colr_a), 0);
        checkOutput("blank de_a", int'(de_a), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
